// File: rtl/MemoryController_Definitions.sv
// Shared memory-controller definitions, including the read-return beat type
// carried from the data buffer through the output skid.
package MemoryController_Definitions;

  localparam int MEM_DATAWIDTH = 32;
  localparam int RD_SKID_DEPTH = 2;

  typedef struct packed {
    logic [MEM_DATAWIDTH-1:0] data;
    logic                     last;
  } rd_beat_t;

endpackage

// File: rtl/read_return_skid.sv
// Two-entry push/pop FIFO of read-return beats; push and pop may coincide,
// including when both entries are occupied.
module read_return_skid
  import MemoryController_Definitions::*;
(
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       push_i,
  input  rd_beat_t   push_beat_i,
  input  logic       pop_i,
  output rd_beat_t   head_o,
  output logic [1:0] cnt_o
);

  rd_beat_t   mem_q [RD_SKID_DEPTH];
  logic       wr_idx_q, wr_idx_d;
  logic       rd_idx_q, rd_idx_d;
  logic [1:0] cnt_q, cnt_d;

  always_comb begin
    wr_idx_d = wr_idx_q ^ push_i;
    rd_idx_d = rd_idx_q ^ pop_i;
    cnt_d    = cnt_q + {1'b0, push_i} - {1'b0, pop_i};
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_idx_q <= 1'b0;
      rd_idx_q <= 1'b0;
      cnt_q    <= 2'd0;
    end else begin
      wr_idx_q <= wr_idx_d;
      rd_idx_q <= rd_idx_d;
      cnt_q    <= cnt_d;
    end
  end

  // When full, the written slot is the head being popped this same cycle.
  always_ff @(posedge clk_i) begin
    if (push_i) mem_q[wr_idx_q] <= push_beat_i;
  end

  assign head_o = mem_q[rd_idx_q];
  assign cnt_o  = cnt_q;

endmodule

// File: rtl/read_return_ctrl.sv
// Read-return pointer/flow controller: PHY beats -> data buffer -> 2-entry skid -> cache.
// Optional simulation checks are enabled with `define READ_RETURN_ASSERT_EN.
module read_return_ctrl
  import MemoryController_Definitions::*;
#(
  parameter  int BufferDepth = 16,
  localparam int PW          = $clog2(BufferDepth)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     phy_valid,
  input  logic [MEM_DATAWIDTH-1:0] phy_data,
  input  logic                     phy_last,
  output logic                     buf_we,
  output logic [PW-1:0]            buf_writePtr,
  output logic [MEM_DATAWIDTH-1:0] buf_wdata,
  output logic                     buf_re,
  output logic [PW-1:0]            buf_readPtr,
  input  logic [MEM_DATAWIDTH-1:0] buf_rdata,
  output logic                     cache_valid,
  output logic [MEM_DATAWIDTH-1:0] cache_data,
  output logic                     cache_last,
  input  logic                     cache_ready,
  output logic [PW:0]              free_cnt,
  output logic                     overflow
);

  localparam logic [PW:0] DEPTH_C = (PW+1)'(BufferDepth);

  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW:0]   count_q, count_d;
  logic          inflight_q;
  logic          last_p1_q;
  logic          overflow_q, overflow_d;
  logic          last_q [BufferDepth];

  logic          full;
  logic          pop;
  logic [2:0]    pending;
  logic [1:0]    skid_cnt;
  rd_beat_t      skid_head;
  rd_beat_t      cap_beat;

  assign full    = (count_q == DEPTH_C);
  assign pop     = cache_valid && cache_ready;
  assign pending = {1'b0, skid_cnt} + {2'b0, inflight_q} - {2'b0, pop};

  assign buf_we       = phy_valid && !full;
  assign buf_writePtr = wr_ptr_q;
  assign buf_wdata    = phy_data;
  // Reserve a skid slot for every read in flight so the skid never overruns.
  assign buf_re       = (count_q != '0) && (pending < 3'd2);
  assign buf_readPtr  = rd_ptr_q;

  assign free_cnt = DEPTH_C - count_q;
  assign overflow = overflow_q;

  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    overflow_d = overflow_q;
    if (buf_we) wr_ptr_d = wr_ptr_q + PW'(1);
    if (buf_re) rd_ptr_d = rd_ptr_q + PW'(1);
    if (phy_valid && full) overflow_d = 1'b1;
    count_d = count_q + (PW+1)'(buf_we) - (PW+1)'(buf_re);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      inflight_q <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      inflight_q <= buf_re;
      overflow_q <= overflow_d;
    end
  end

  // Stage 1: last flag travels with the buffer's registered read.
  always_ff @(posedge clk) begin
    if (buf_we) last_q[wr_ptr_q] <= phy_last;
    if (buf_re) last_p1_q <= last_q[rd_ptr_q];
  end

  // Stage 2: capture into the output skid.
  assign cap_beat = {buf_rdata, last_p1_q};

  read_return_skid u_skid (
    .clk_i       (clk),
    .rst_ni      (rst),
    .push_i      (inflight_q),
    .push_beat_i (cap_beat),
    .pop_i       (pop),
    .head_o      (skid_head),
    .cnt_o       (skid_cnt)
  );

  assign cache_valid = (skid_cnt != 2'd0);
  assign cache_data  = cache_valid ? skid_head.data : '0;
  assign cache_last  = cache_valid && skid_head.last;

`ifdef READ_RETURN_ASSERT_EN
  always @(posedge clk) begin
    if (rst) begin
      if (phy_valid && full)
        $fatal(1, "read_return_ctrl: beat arrived while buffer full");
      if (buf_re && buf_we && (buf_readPtr == buf_writePtr))
        $fatal(1, "read_return_ctrl: same-address read and write");
      if (count_q > DEPTH_C)
        $fatal(1, "read_return_ctrl: occupancy out of range");
      if (skid_cnt > 2'(RD_SKID_DEPTH))
        $fatal(1, "read_return_ctrl: skid count out of range");
    end
  end

  property p_stall_stable;
    @(posedge clk) disable iff (!rst)
      (cache_valid && !cache_ready) |=> (cache_valid && $stable(cache_data));
  endproperty
  a_stall_stable: assert property (p_stall_stable)
    else $fatal(1, "read_return_ctrl: output changed while stalled");
`else
  // Overflow remains observable through the sticky overflow output.
`endif

endmodule
